// File: rtl/mult_bus_if.sv
// Host handshake and 6502-style peripheral bus bundle for mult_bus_master.
// The master modport is the initiator's view; slave is the host/peripheral view.
interface mult_bus_if;
    logic        start;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        ready;
    logic        done;
    logic [15:0] result;
    logic        ce;
    logic        rwb;
    logic [1:0]  addr;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [7:0]  d_in;

    modport master (
        input  start, op_a, op_b, d_in,
        output ready, done, result, ce, rwb, addr, d_out, d_oe
    );

    modport slave (
        output start, op_a, op_b, d_in,
        input  ready, done, result, ce, rwb, addr, d_out, d_oe
    );
endinterface

// File: rtl/mult_bus_master.sv
// Bus initiator: writes operands A/B to a multiply peripheral, optionally waits,
// reads the 16-bit product back byte by byte and pulses done.
module mult_bus_master #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic        clk,
    input logic        rst,
    mult_bus_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR_A, S_WR_B, S_WAIT, S_RD_LO, S_RD_HI, S_DONE
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state_q;
    logic [7:0]  op_b_q;
    logic [3:0]  cnt_q;
    logic        ce_q;
    logic        rwb_q;
    logic [1:0]  addr_q;
    logic [7:0]  d_out_q;
    logic        d_oe_q;
    logic        ready_q;
    logic        done_q;
    logic [15:0] result_q;

    // Outputs are registered, so each branch programs the bus for the state it enters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_b_q   <= 8'h00;
            cnt_q    <= 4'd0;
            ce_q     <= 1'b0;
            rwb_q    <= 1'b1;
            addr_q   <= 2'd0;
            d_out_q  <= 8'h00;
            d_oe_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            result_q <= 16'h0000;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        op_b_q  <= bus.op_b;
                        d_out_q <= bus.op_a;
                        ready_q <= 1'b0;
                        ce_q    <= 1'b1;
                        rwb_q   <= 1'b0;
                        addr_q  <= 2'd0;
                        d_oe_q  <= 1'b1;
                        state_q <= S_WR_A;
                    end
                end
                S_WR_A: begin
                    addr_q  <= 2'd1;
                    d_out_q <= op_b_q;
                    state_q <= S_WR_B;
                end
                S_WR_B: begin
                    rwb_q  <= 1'b1;
                    d_oe_q <= 1'b0;
                    cnt_q  <= WAIT_LOAD;
                    if (WAIT_CYCLES > 0) begin
                        ce_q    <= 1'b0;
                        state_q <= S_WAIT;
                    end else begin
                        addr_q  <= 2'd2;
                        state_q <= S_RD_LO;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        ce_q    <= 1'b1;
                        addr_q  <= 2'd2;
                        state_q <= S_RD_LO;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RD_LO: begin
                    result_q[7:0] <= bus.d_in;
                    addr_q        <= 2'd3;
                    state_q       <= S_RD_HI;
                end
                S_RD_HI: begin
                    result_q[15:8] <= bus.d_in;
                    ce_q           <= 1'b0;
                    done_q         <= 1'b1;
                    state_q        <= S_DONE;
                end
                S_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    ce_q    <= 1'b0;
                    rwb_q   <= 1'b1;
                    d_oe_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ce     = ce_q;
    assign bus.rwb    = rwb_q;
    assign bus.addr   = addr_q;
    assign bus.d_out  = d_out_q;
    assign bus.d_oe   = d_oe_q;
    assign bus.ready  = ready_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_mult_bus_master.sv
// Self-checking bench: three masters (W=1, W=0, W=2), each talking to a
// behavioural multiply peripheral, checked cycle by cycle against the bus timeline.
module tb_mult_bus_master;
    localparam int NDUT = 3;

    typedef struct packed {
        logic       ce;
        logic       rwb;
        logic       doe;
        logic       done;
        logic       ready;
        logic [1:0] addr;
        logic [7:0] dout;
    } busObs_t;

    typedef struct {
        int          k;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] expRes;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic        startR [NDUT];
    logic [7:0]  opAR   [NDUT];
    logic [7:0]  opBR   [NDUT];
    logic        ceW    [NDUT];
    logic        rwbW   [NDUT];
    logic        doeW   [NDUT];
    logic        readyW [NDUT];
    logic        doneW  [NDUT];
    logic [1:0]  addrW  [NDUT];
    logic [7:0]  doutW  [NDUT];
    logic [15:0] resultW[NDUT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_bus_if bus [NDUT] ();

    generate
        for (genvar g = 0; g < NDUT; g++) begin : gDut
            logic [7:0]  perA;
            logic [7:0]  perB;
            logic [15:0] prod;
            logic [7:0]  din;

            assign bus[g].start = startR[g];
            assign bus[g].op_a  = opAR[g];
            assign bus[g].op_b  = opBR[g];
            assign bus[g].d_in  = din;
            assign ceW[g]     = bus[g].ce;
            assign rwbW[g]    = bus[g].rwb;
            assign doeW[g]    = bus[g].d_oe;
            assign readyW[g]  = bus[g].ready;
            assign doneW[g]   = bus[g].done;
            assign addrW[g]   = bus[g].addr;
            assign doutW[g]   = bus[g].d_out;
            assign resultW[g] = bus[g].result;

            mult_bus_master #(.WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 2))) dut (
                .clk (clk),
                .rst (rst),
                .bus (bus[g])
            );

            // Peripheral: registers A/B latched on write cycles, product read combinationally.
            always @(posedge clk) begin
                if (rst) begin
                    perA <= 8'h00;
                    perB <= 8'h00;
                end else if (ceW[g] && !rwbW[g]) begin
                    if (addrW[g] == 2'd0) perA <= doutW[g];
                    else if (addrW[g] == 2'd1) perB <= doutW[g];
                end
            end

            always_comb begin
                prod = 16'(perA) * 16'(perB);
                din  = 8'h00;
                if (ceW[g] && rwbW[g]) begin
                    if (addrW[g] == 2'd2) din = prod[7:0];
                    else if (addrW[g] == 2'd3) din = prod[15:8];
                end
            end
        end
    endgenerate

    function automatic int wOf(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 2);
    endfunction

    // Expected bus picture for cycle c after acceptance (c=1 is the A write).
    function automatic busObs_t expectCycle(input int c, input int w, input logic [7:0] a, input logic [7:0] b);
        busObs_t e;
        e = '0;
        e.rwb   = 1'b1;
        e.ready = (c > 5 + w);
        if (c == 1) begin
            e.ce = 1'b1; e.rwb = 1'b0; e.doe = 1'b1; e.addr = 2'd0; e.dout = a;
        end else if (c == 2) begin
            e.ce = 1'b1; e.rwb = 1'b0; e.doe = 1'b1; e.addr = 2'd1; e.dout = b;
        end else if (c == 3 + w) begin
            e.ce = 1'b1; e.addr = 2'd2;
        end else if (c == 4 + w) begin
            e.ce = 1'b1; e.addr = 2'd3;
        end else if (c == 5 + w) begin
            e.done = 1'b1;
        end
        return e;
    endfunction

    function automatic busObs_t observe(input int k, input busObs_t e);
        busObs_t o;
        o       = '0;
        o.ce    = ceW[k];
        o.rwb   = rwbW[k];
        o.doe   = doeW[k];
        o.done  = doneW[k];
        o.ready = readyW[k];
        o.addr  = e.ce ? addrW[k] : 2'd0;
        o.dout  = (e.ce && !e.rwb) ? doutW[k] : 8'h00;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Waits (bounded) for ready at a negedge, then presents one request for one edge.
    task automatic applyStimulus(input int k, input logic [7:0] a, input logic [7:0] b);
        int guard = 0;
        while (!readyW[k] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!readyW[k]) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready timeout dut%0d: got 0 want 1", k);
        end
        startR[k] = 1'b1;
        opAR[k]   = a;
        opBR[k]   = b;
        @(negedge clk);
        startR[k] = 1'b0;
    endtask

    // Called at the negedge of cycle 1; walks to the negedge of cycle 6+W.
    task automatic checkOutput(input int k, input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] expRes, input int injCycle);
        int w = wOf(k);
        busObs_t e;
        busObs_t o;
        for (int c = 1; c <= 6 + w; c++) begin
            e = expectCycle(c, w, a, b);
            o = observe(k, e);
            check($sformatf("dut%0d cyc%0d bus", k, c), 32'(o), 32'(e));
            if (c == 4 + w) check($sformatf("dut%0d low byte", k), 32'(resultW[k][7:0]), 32'(expRes[7:0]));
            if (c == 5 + w) check($sformatf("dut%0d result", k), 32'(resultW[k]), 32'(expRes));
            if (c == injCycle) begin
                startR[k] = 1'b1;
                opAR[k]   = 8'h11;
                opBR[k]   = 8'h22;
            end else begin
                startR[k] = 1'b0;
            end
            if (c < 6 + w) @(negedge clk);
        end
        startR[k] = 1'b0;
    endtask

    vec_t vecs [6];
    int   doneAt [$];
    int   badCycles;
    int   guard;
    logic [7:0] ra;
    logic [7:0] rb;
    int   rk;

    initial begin
        vecs[0] = '{0, 8'h0C, 8'h0A, 16'h0078};
        vecs[1] = '{0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[2] = '{1, 8'h80, 8'h02, 16'h0100};
        vecs[3] = '{1, 8'h00, 8'h37, 16'h0000};
        vecs[4] = '{2, 8'hFF, 8'h01, 16'h00FF};
        vecs[5] = '{1, 8'hFF, 8'hFF, 16'hFE01};

        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            startR[k] = 1'b0;
            opAR[k]   = 8'h00;
            opBR[k]   = 8'h00;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < NDUT; k++)
            check($sformatf("dut%0d reset state", k),
                  {ceW[k], rwbW[k], addrW[k], doutW[k], doeW[k], readyW[k], doneW[k], resultW[k]},
                  {1'b0, 1'b1, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000});
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].k, vecs[i].a, vecs[i].b);
            checkOutput(vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].expRes, 0);
        end

        // Start pulse during WR_B must be ignored and produce no extra bus cycles.
        applyStimulus(0, 8'h03, 8'h05);
        checkOutput(0, 8'h03, 8'h05, 16'h000F, 2);
        badCycles = 0;
        repeat (8) begin
            @(negedge clk);
            if (ceW[0] || !readyW[0] || doneW[0]) badCycles++;
        end
        check("ignored start extra cycles", 32'(badCycles), 32'd0);

        // Reset in the RD_LO cycle aborts the transaction silently.
        applyStimulus(0, 8'h07, 8'h09);
        repeat (3) @(negedge clk);
        check("rd_lo before reset", {ceW[0], rwbW[0], addrW[0]}, {1'b1, 1'b1, 2'd2});
        rst = 1'b1;
        @(negedge clk);
        check("abort state", {ceW[0], doeW[0], rwbW[0], readyW[0], doneW[0], resultW[0]},
              {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000});
        rst = 1'b0;
        badCycles = 0;
        repeat (8) begin
            @(negedge clk);
            if (doneW[0] || ceW[0]) badCycles++;
        end
        check("no done after abort", 32'(badCycles), 32'd0);
        applyStimulus(0, 8'h02, 8'h03);
        checkOutput(0, 8'h02, 8'h03, 16'h0006, 0);

        // Start held high on the W=2 master: one transaction every 8 cycles.
        startR[2] = 1'b1;
        opAR[2]   = 8'h0D;
        opBR[2]   = 8'h0B;
        badCycles = 0;
        for (int cyc = 0; cyc < 42; cyc++) begin
            if (doneW[2]) begin
                doneAt.push_back(cyc);
                check("held start result", 32'(resultW[2]), 32'h008F);
            end
            if (!(ceW[2] && !rwbW[2]) && (doeW[2] || !rwbW[2])) badCycles++;
            if (doeW[2] && rwbW[2]) badCycles++;
            @(negedge clk);
        end
        startR[2] = 1'b0;
        check("held start done count", 32'(doneAt.size()), 32'd5);
        if (doneAt.size() > 0) check("held start first done", 32'(doneAt[0]), 32'd7);
        for (int i = 1; i < doneAt.size(); i++)
            check($sformatf("done spacing %0d", i), 32'(doneAt[i] - doneAt[i-1]), 32'd8);
        check("non-write bus idle values", 32'(badCycles), 32'd0);
        guard = 0;
        while (!readyW[2] && guard < 20) begin
            @(negedge clk);
            guard++;
        end

        // Random operands on random masters against plain multiplication.
        for (int i = 0; i < 20; i++) begin
            rk = $urandom_range(0, NDUT - 1);
            ra = 8'($urandom);
            rb = 8'($urandom);
            applyStimulus(rk, ra, rb);
            checkOutput(rk, ra, rb, 16'(ra) * 16'(rb), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_bus_master.md
# mult_bus_master

Bus initiator that drives the 8-bit, 6502-style peripheral bus used by the multiplication accelerator. It accepts an operand pair over a valid/ready handshake and runs a fixed bus sequence: write operand A, write operand B, optional settle wait, read result low byte, read result high byte. It then returns the 16-bit product with a one-cycle done pulse. It sits between a host-side controller (or a test harness) and any memory-mapped multiply peripheral with the register map below.

## Interface

Parameters:
- WAIT_CYCLES, default 1: idle bus cycles inserted between the B write and the low-byte read; legal range 0–15.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request valid; accepted on a rising edge where start && ready
- op_a  input  8  operand A, captured at acceptance
- op_b  input  8  operand B, captured at acceptance
- ready  output  1  high only in IDLE
- done  output  1  one-cycle pulse; result valid and stable from this cycle
- result  output  16  {high byte, low byte} read from the peripheral; held until the next done
- ce  output  1  bus chip enable; high for exactly one clock per bus cycle
- rwb  output  1  1 = read, 0 = write (6502 convention)
- addr  output  2  register select: 0 = A, 1 = B, 2 = product[7:0], 3 = product[15:8]
- d_out  output  8  write data
- d_oe  output  1  write-data drive enable; the top level tristates d_out onto the shared data bus with it
- d_in  input  8  read data from the shared bus

## Operation

- All outputs are registered. Reset values: ce=0, rwb=1, addr=0, d_out=0, d_oe=0, ready=1, done=0, result=0, state=IDLE, wait counter=0.
- States: IDLE, WR_A, WR_B, WAIT, RD_LO, RD_HI, DONE.
- IDLE: ready=1. On start, capture op_a/op_b into internal registers and go to WR_A. If start is low, stay.
- WR_A: ce=1, rwb=0, addr=0, d_oe=1, d_out=captured A. Go to WR_B.
- WR_B: ce=1, rwb=0, addr=1, d_oe=1, d_out=captured B. Go to WAIT if WAIT_CYCLES>0, otherwise to RD_LO. Load the counter with WAIT_CYCLES-1.
- WAIT: ce=0, d_oe=0, rwb=1. Decrement the counter. Go to RD_LO when the counter is 0.
- RD_LO: ce=1, rwb=1, addr=2, d_oe=0. Sample d_in into result[7:0] on the edge that ends the cycle. Go to RD_HI.
- RD_HI: ce=1, rwb=1, addr=3. Sample d_in into result[15:8] on the edge that ends the cycle. Go to DONE.
- DONE: ce=0, done=1, ready=0. Go to IDLE.
- Outside the bus states: ce=0, d_oe=0, rwb=1, and addr/d_out hold their last values.
- d_oe is never high while rwb=1.
- start while ready=0 (including the DONE cycle) is ignored. The operand registers are not disturbed.
- result updates only in RD_LO/RD_HI sampling. A new transaction's partial low byte becomes visible after its RD_LO cycle. The consumer uses result only at or after done.
- The block does no arithmetic. result is exactly the two bytes read, with no width extension or masking.
- Reset mid-transaction: on the next edge, state=IDLE and all outputs take their reset values. No done pulse; the captured operands are discarded.
- Simultaneous rst and start: rst wins; the request is not accepted.

## Timing

- Edge 0 accepts the request. WR_A is driven in cycle 1 and WR_B in cycle 2. WAIT occupies cycles 3 … 2+W, where W = WAIT_CYCLES. RD_LO is in cycle 3+W, RD_HI in cycle 4+W, DONE in cycle 5+W.
- Accept-to-done latency: 5+W cycles. ready returns high in cycle 6+W.
- Back-to-back throughput: one transaction per 6+W cycles. The earliest next acceptance is the edge ending cycle 6+W.
- Read data must be valid on d_in by the end of its ce cycle; the peripheral is combinational-read.
- Every ce pulse is exactly one clock wide. For W=0 there are four consecutive ce-high cycles with no gap.

## Test plan

- W=1, op_a=0x0C, op_b=0x0A, with a bench peripheral model computing the product. Required response: writes (addr0,0x0C) then (addr1,0x0A), one ce-low cycle, reads at addr2 then addr3, done 6 cycles after acceptance, result=0x0078.
- W=1, 0xFF × 0xFF. Required: result=0xFE01. The sampled bytes are 0x01 at addr2 and 0xFE at addr3.
- W=0, 0x80 × 0x02. Required: four consecutive ce cycles, done 5 cycles after acceptance, result=0x0100.
- Pulse start with 0x11/0x22 during WR_B of an active 0x03×0x05 transaction. Required: the pulse is ignored, result=0x000F, and there are no additional bus cycles.
- Assert rst during RD_LO. Required: next cycle ce=0, d_oe=0, rwb=1, ready=1, result=0, and no done pulse. A following 0x02×0x03 request completes with result=0x0006.
- Hold start high continuously with a fixed operand pair, W=2. Required: each transaction takes exactly 8 cycles, done pulses are 8 cycles apart, and rwb=1 with d_oe=0 in every non-write cycle.
